// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing the CSR file's HTIF PCR port between two host-side requesters.
// One transaction in flight; the CSR-side request and the requester responses come from flops.
module vscale_htif_pcr_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,

    output logic              pcr_req_valid,
    input  logic              pcr_req_ready,
    output logic              pcr_req_rw,
    output logic [ADDR_W-1:0] pcr_req_addr,
    output logic [DATA_W-1:0] pcr_req_data,
    input  logic              pcr_resp_valid,
    output logic              pcr_resp_ready,
    input  logic [DATA_W-1:0] pcr_resp_data,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              prio;
    logic              prio_next;
    logic              owner_next;
    logic              grant1_c;
    logic              accept_c;
    logic              load_resp_c;
    logic              resp_taken_c;
    logic [DATA_W-1:0] resp_data_q;

    // Requester 1 wins when it is the only one asking or when it holds priority.
    always_comb begin
        grant1_c   = req1_valid && (!req0_valid || prio);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((state == IDLE) && !reset) begin
            req0_ready = req0_valid && !grant1_c;
            req1_ready = grant1_c;
        end
    end

    assign accept_c     = req0_ready || req1_ready;
    assign resp_taken_c = owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        prio_next   = prio;
        owner_next  = owner;
        load_resp_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = ISSUE;
                    owner_next = grant1_c;
                end
            end
            ISSUE: begin
                if (pcr_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (pcr_resp_valid) begin
                    state_next  = RESP;
                    load_resp_c = 1'b1;
                end
            end
            RESP: begin
                // Pointer only advances once the owner has taken its response.
                if (resp_taken_c) begin
                    state_next = IDLE;
                    prio_next  = ~owner;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so both sides see flop-driven controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio           <= 1'b0;
            owner          <= 1'b0;
            busy           <= 1'b0;
            pcr_req_valid  <= 1'b0;
            pcr_resp_ready <= 1'b0;
            resp0_valid    <= 1'b0;
            resp1_valid    <= 1'b0;
            pcr_req_rw     <= 1'b0;
            pcr_req_addr   <= '0;
            pcr_req_data   <= '0;
            resp_data_q    <= '0;
        end else begin
            prio           <= prio_next;
            owner          <= owner_next;
            busy           <= (state_next != IDLE);
            pcr_req_valid  <= (state_next == ISSUE);
            pcr_resp_ready <= (state_next == WAIT);
            resp0_valid    <= (state_next == RESP) && !owner_next;
            resp1_valid    <= (state_next == RESP) && owner_next;
            if (accept_c) begin
                pcr_req_rw   <= grant1_c ? req1_rw   : req0_rw;
                pcr_req_addr <= grant1_c ? req1_addr : req0_addr;
                pcr_req_data <= grant1_c ? req1_data : req0_data;
            end
            if (load_resp_c) begin
                resp_data_q <= pcr_resp_data;
            end
        end
    end

    assign resp0_data = resp_data_q;
    assign resp1_data = resp_data_q;

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Bench for vscale_htif_pcr_arbiter: two requester agents, a CSR-file stub and a
// transaction-level reference model of arbitration, routing and CSR contents.
module tb_vscale_htif_pcr_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_rw;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_data [2];
    logic              pcr_req_valid;
    logic              pcr_req_ready;
    logic              pcr_req_rw;
    logic [ADDR_W-1:0] pcr_req_addr;
    logic [DATA_W-1:0] pcr_req_data;
    logic              pcr_resp_valid;
    logic              pcr_resp_ready;
    logic [DATA_W-1:0] pcr_resp_data;
    logic              busy;
    logic              owner;

    vscale_htif_pcr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_rw(req_rw[0]),
        .req0_addr(req_addr[0]), .req0_data(req_data[0]),
        .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]), .resp0_data(resp_data[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_rw(req_rw[1]),
        .req1_addr(req_addr[1]), .req1_data(req_data[1]),
        .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]), .resp1_data(resp_data[1]),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready), .pcr_req_rw(pcr_req_rw),
        .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
        .pcr_resp_data(pcr_resp_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester queues, CSR contents (stub and reference), environment knobs.
    req_t              q0 [$];
    req_t              q1 [$];
    logic [DATA_W-1:0] csr_mem [4096];
    logic [DATA_W-1:0] ref_mem [4096];
    bit                rnd       = 1'b0;
    int                csr_lat   = 0;
    int                req_stall = 0;
    int                resp_hold [2];

    // Reference model: 0 idle, 1 request at CSR, 2 awaiting CSR, 3 response at requester.
    int                phase   = 0;
    bit                m_owner = 1'b0;
    bit                m_prio  = 1'b0;
    req_t              m_req;
    logic [DATA_W-1:0] m_exp;

    int                cyc = 0;
    int                acc_cyc = 0;
    int                lat_last = 0;
    bit                first_resp_seen = 1'b0;
    int                pcr_cycles = 0;
    int                resp_cycles = 0;
    int                completions = 0;
    int                comp_log [$];
    int                pcr_log [$];
    int                resp_log [$];
    logic [DATA_W-1:0] last_resp_data = '0;
    logic [1:0]        resp_seen = 2'b00;

    function automatic int q_size(input int n);
        return (n == 0) ? q0.size() : q1.size();
    endfunction

    function automatic req_t q_front(input int n);
        return (n == 0) ? q0[0] : q1[0];
    endfunction

    // Environment: inputs change on the falling edge; handshakes are judged 1 ns later.
    initial begin : env
        req_t       r;
        bit         rst_f;
        logic [1:0] hs_req;
        logic [1:0] hs_resp;
        bit         hs_pcr_req;
        bit         hs_pcr_resp;
        bit         st_pending;
        int         st_wait;
        logic [DATA_W-1:0] st_data;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        logic [DATA_W-1:0] got_data;
        rst_f = 1'b1; hs_req = '0; hs_resp = '0; hs_pcr_req = 1'b0; hs_pcr_resp = 1'b0;
        st_pending = 1'b0; st_wait = 0; st_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_f) begin
                st_pending     = 1'b0;
                pcr_resp_valid = 1'b0;
                phase          = 0;
                m_prio         = 1'b0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (hs_req[n]) begin
                        m_req = q_front(n);
                        if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        m_owner = (n == 1);
                        phase = 1;
                        acc_cyc = cyc - 1;
                        first_resp_seen = 1'b0;
                        pcr_cycles = 0;
                        resp_cycles = 0;
                    end
                end
                if (hs_pcr_req) begin
                    st_data = csr_mem[pcr_req_addr];
                    if (pcr_req_rw) csr_mem[pcr_req_addr] = pcr_req_data;
                    st_pending = 1'b1;
                    st_wait = rnd ? int'($urandom_range(0, 3)) : csr_lat;
                    m_exp = ref_mem[m_req.addr];
                    if (m_req.rw) ref_mem[m_req.addr] = m_req.data;
                    phase = 2;
                end
                if (hs_pcr_resp) begin
                    pcr_resp_valid = 1'b0;
                    phase = 3;
                end
                for (int n = 0; n < 2; n++) begin
                    if (hs_resp[n]) begin
                        phase = 0;
                        m_prio = (n == 0);
                        completions++;
                        comp_log.push_back(n);
                        pcr_log.push_back(pcr_cycles);
                        resp_log.push_back(resp_cycles);
                    end
                end
            end
            // CSR stub drive
            if (st_pending && !pcr_resp_valid) begin
                if (st_wait == 0) begin
                    pcr_resp_valid = 1'b1;
                    st_pending = 1'b0;
                end else begin
                    st_wait--;
                end
            end
            pcr_resp_data = pcr_resp_valid ? st_data : {$urandom, $urandom};
            if (pcr_req_valid && req_stall > 0) begin
                pcr_req_ready = 1'b0;
                req_stall--;
            end else begin
                pcr_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            // Requester drive
            for (int n = 0; n < 2; n++) begin
                if (q_size(n) > 0) begin
                    r = q_front(n);
                    req_valid[n] = 1'b1;
                    req_rw[n]    = r.rw;
                    req_addr[n]  = r.addr;
                    req_data[n]  = r.data;
                end else begin
                    req_valid[n] = 1'b0;
                    req_rw[n]    = 1'($urandom_range(0, 1));
                    req_addr[n]  = 12'($urandom);
                    req_data[n]  = {$urandom, $urandom};
                end
                if (resp_hold[n] > 0) begin
                    resp_ready[n] = 1'b0;
                    if (resp_valid[n]) resp_hold[n]--;
                end else begin
                    resp_ready[n] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            #1;
            rst_f = reset;
            hs_req = '0; hs_resp = '0; hs_pcr_req = 1'b0; hs_pcr_resp = 1'b0;
            if (!reset) begin
                hs_req      = req_valid & req_ready;
                hs_resp     = resp_valid & resp_ready;
                hs_pcr_req  = pcr_req_valid && pcr_req_ready;
                hs_pcr_resp = pcr_resp_valid && pcr_resp_ready;
                resp_seen   = resp_seen | resp_valid;
                exp_rdy = 2'b00;
                if (phase == 0) begin
                    exp_rdy[0] = req_valid[0] && !(req_valid[1] && m_prio);
                    exp_rdy[1] = req_valid[1] && !(req_valid[0] && !m_prio);
                end
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL grant cyc %0d: ready %b expected %b", cyc, req_ready, exp_rdy);
                end
                n_checks++;
                if (busy !== (phase != 0)) begin
                    n_fail++;
                    $display("FAIL busy cyc %0d: got %b expected %b", cyc, busy, phase != 0);
                end
                if (phase != 0) begin
                    n_checks++;
                    if (owner !== m_owner) begin
                        n_fail++;
                        $display("FAIL owner cyc %0d: got %b expected %b", cyc, owner, m_owner);
                    end
                end
                n_checks++;
                if (pcr_req_valid !== (phase == 1)) begin
                    n_fail++;
                    $display("FAIL pcr_req_valid cyc %0d: got %b expected %b", cyc, pcr_req_valid, phase == 1);
                end
                if (phase == 1) begin
                    pcr_cycles++;
                    n_checks++;
                    if ({pcr_req_rw, pcr_req_addr, pcr_req_data} !== m_req) begin
                        n_fail++;
                        $display("FAIL pcr_req fields cyc %0d: got %h expected %h", cyc,
                                 {pcr_req_rw, pcr_req_addr, pcr_req_data}, m_req);
                    end
                end
                n_checks++;
                if (pcr_resp_ready !== (phase == 2)) begin
                    n_fail++;
                    $display("FAIL pcr_resp_ready cyc %0d: got %b expected %b", cyc, pcr_resp_ready, phase == 2);
                end
                exp_rv = 2'b00;
                if (phase == 3) exp_rv = m_owner ? 2'b10 : 2'b01;
                n_checks++;
                if (resp_valid !== exp_rv) begin
                    n_fail++;
                    $display("FAIL resp_valid cyc %0d: got %b expected %b", cyc, resp_valid, exp_rv);
                end
                if (phase == 3) begin
                    got_data = m_owner ? resp_data[1] : resp_data[0];
                    n_checks++;
                    if (got_data !== m_exp) begin
                        n_fail++;
                        $display("FAIL resp_data cyc %0d: got %h expected %h", cyc, got_data, m_exp);
                    end
                    resp_cycles++;
                    last_resp_data = got_data;
                    if (!first_resp_seen) begin
                        lat_last = cyc - acc_cyc;
                        first_resp_seen = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_comp(input int target, input int budget, input string what);
        int k;
        k = 0;
        while (completions < target && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (completions < target) begin
            n_fail++;
            $display("FAIL %s timeout: completions %0d expected %0d", what, completions, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({req_ready, resp_valid, pcr_req_valid, pcr_resp_ready, busy, owner} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset controls: got %b expected 00000000",
                     {req_ready, resp_valid, pcr_req_valid, pcr_resp_ready, busy, owner});
        end
        n_checks++;
        if ({pcr_req_rw, pcr_req_addr, pcr_req_data, resp_data[0]} !== '0) begin
            n_fail++;
            $display("FAIL reset data: got %h/%h/%h/%h expected 0", pcr_req_rw, pcr_req_addr,
                     pcr_req_data, resp_data[0]);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        int base;
        base = completions;
        resp_seen = 2'b00;
        q0.push_back('{rw: 1'b0, addr: 12'h780, data: 64'hDEAD_BEEF_0000_1111});
        wait_comp(base + 1, 50, "single_read");
        n_checks++;
        if (lat_last !== 3) begin
            n_fail++;
            $display("FAIL single_read latency: got %0d expected 3", lat_last);
        end
        n_checks++;
        if (last_resp_data !== 64'h5) begin
            n_fail++;
            $display("FAIL single_read data: got %h expected 5", last_resp_data);
        end
        n_checks++;
        if (resp_seen[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read resp1: got %b expected 0", resp_seen[1]);
        end
    endtask

    task automatic test_contention();
        int base;
        reset = 1'b1;
        step();
        reset = 1'b0;
        base = completions;
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{rw: 1'b0, addr: 12'(12'h782 + i), data: 64'h0});
            q1.push_back('{rw: 1'b0, addr: 12'(12'h790 + i), data: 64'h0});
        end
        wait_comp(base + 6, 200, "contention");
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (comp_log.size() > base + i && comp_log[base + i] !== (i % 2)) begin
                n_fail++;
                $display("FAIL contention order[%0d]: got %0d expected %0d", i, comp_log[base + i], i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int k;
        base = completions;
        req_stall = 5;
        resp_hold[0] = 3;
        q0.push_back('{rw: 1'b0, addr: 12'h783, data: 64'h0});
        k = 0;
        while (phase != 3 && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (phase != 3) begin
            n_fail++;
            $display("FAIL backpressure reach_resp: phase %0d expected 3", phase);
        end
        q1.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
        wait_comp(base + 2, 100, "backpressure");
        if (comp_log.size() >= base + 2) begin
            n_checks++;
            if (comp_log[base] !== 0 || comp_log[base + 1] !== 1) begin
                n_fail++;
                $display("FAIL backpressure order: got %0d,%0d expected 0,1", comp_log[base], comp_log[base + 1]);
            end
            n_checks++;
            if (pcr_log[base] !== 6) begin
                n_fail++;
                $display("FAIL backpressure issue_cycles: got %0d expected 6", pcr_log[base]);
            end
            n_checks++;
            if (resp_log[base] !== 4) begin
                n_fail++;
                $display("FAIL backpressure resp_cycles: got %0d expected 4", resp_log[base]);
            end
        end
    endtask

    task automatic test_write();
        int base;
        base = completions;
        q1.push_back('{rw: 1'b1, addr: 12'h781, data: 64'h1234});
        wait_comp(base + 1, 50, "write");
        n_checks++;
        if (last_resp_data !== 64'h0) begin
            n_fail++;
            $display("FAIL write old_value: got %h expected 0", last_resp_data);
        end
        q0.push_back('{rw: 1'b0, addr: 12'h781, data: 64'h0});
        wait_comp(base + 2, 50, "write_readback");
        n_checks++;
        if (last_resp_data !== 64'h1234) begin
            n_fail++;
            $display("FAIL write readback: got %h expected 1234", last_resp_data);
        end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        int k;
        csr_lat = 6;
        q0.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
        k = 0;
        while (phase != 2 && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (phase != 2) begin
            n_fail++;
            $display("FAIL reset_mid_wait reach_wait: phase %0d expected 2", phase);
        end
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({busy, resp_valid, pcr_req_valid, pcr_resp_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait idle: got %b expected 00000",
                     {busy, resp_valid, pcr_req_valid, pcr_resp_ready});
        end
        reset = 1'b0;
        csr_lat = 0;
        base = completions;
        resp_seen = 2'b00;
        repeat (10) step();
        n_checks++;
        if (resp_seen !== 2'b00 || completions !== base) begin
            n_fail++;
            $display("FAIL reset_mid_wait dropped: resp_seen %b completions %0d expected 00 %0d",
                     resp_seen, completions, base);
        end
        q0.push_back('{rw: 1'b0, addr: 12'h780, data: 64'h0});
        wait_comp(base + 1, 50, "reset_mid_wait_next");
        n_checks++;
        if (last_resp_data !== 64'h5) begin
            n_fail++;
            $display("FAIL reset_mid_wait next_data: got %h expected 5", last_resp_data);
        end
    endtask

    task automatic test_random();
        int base;
        int pushed;
        req_t r;
        base = completions;
        pushed = 0;
        rnd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r.rw   = 1'($urandom_range(0, 1));
                    r.addr = 12'(12'h780 + $urandom_range(0, 3));
                    r.data = {$urandom, $urandom};
                    if (n == 0) q0.push_back(r); else q1.push_back(r);
                    pushed++;
                end
            end
            step();
        end
        wait_comp(base + pushed, 4000, "random");
        rnd = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        req_valid = '0; req_rw = '0; resp_ready = '0;
        req_addr[0] = '0; req_addr[1] = '0; req_data[0] = '0; req_data[1] = '0;
        pcr_req_ready = 1'b0; pcr_resp_valid = 1'b0; pcr_resp_data = '0;
        resp_hold[0] = 0; resp_hold[1] = 0;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = {32'hC5A0_0000, 20'h0, 12'(i)};
        end
        csr_mem[12'h780] = 64'h5;
        csr_mem[12'h781] = 64'h0;
        ref_mem = csr_mem;
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_write();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
